// File: rtl/uart_pkg.sv
// Shared constants, state types and byte-select helper for the UART loopback slice.
package uart_pkg;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 115_200;
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int NBYTES   = 8;

  // The TX FSM is split: IDLE/LOAD/NEXT live in the byte sequencer,
  // IDLE/START/DATA/STOP in the serialiser.
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_NEXT
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Byte idx of a 64-bit word, MSB byte first: bits [63-8*idx -: 8].
  function automatic logic [7:0] byte_sel(input logic [63:0] word, input logic [2:0] idx);
    return word[{~idx, 3'b111} -: 8];
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 byte serialiser. A new byte is accepted while idle or in the last
// cycle of the stop bit, so consecutive frames run with no idle gap.
//
// state    | meaning
// ---------+------------------------------------------
// TX_IDLE  | line held at 1, waiting for start
// TX_START | start bit (0) for BAUD_DIV cycles
// TX_DATA  | 8 data bits, LSB first, BAUD_DIV cycles each
// TX_STOP  | stop bit (1); last cycle raises done/ready
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = uart_pkg::BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       line,
  output logic       busy,
  output logic       ready,
  output logic       done
);

  localparam int TW = $clog2(BAUD_DIV);
  localparam logic [TW-1:0] BIT_LAST = TW'(BAUD_DIV - 1);

  tx_state_t     state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          line_nx;
  logic          tc;

  assign tc    = (timer == '0);
  assign done  = (state == TX_STOP) && tc;
  assign ready = (state == TX_IDLE) || done;
  assign busy  = (state != TX_IDLE);

  // State, bit timer, shift register and registered line output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      line    <= 1'b1;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
      line    <= line_nx;
    end
  end

  // Next-state: count down each bit, advance on terminal count.
  always_comb begin
    state_nx   = state;
    timer_nx   = tc ? timer : timer - TW'(1);
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    line_nx    = line;
    case (state)
      TX_IDLE: line_nx = 1'b1;
      TX_START: begin
        if (tc) begin
          state_nx   = TX_DATA;
          timer_nx   = BIT_LAST;
          line_nx    = shreg[0];
          shreg_nx   = {1'b0, shreg[7:1]};
          bit_idx_nx = '0;
        end
      end
      TX_DATA: begin
        if (tc) begin
          timer_nx = BIT_LAST;
          if (bit_idx == 3'd7) begin
            state_nx = TX_STOP;
            line_nx  = 1'b1;
          end else begin
            line_nx    = shreg[0];
            shreg_nx   = {1'b0, shreg[7:1]};
            bit_idx_nx = bit_idx + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (tc) begin
          state_nx = TX_IDLE;
          line_nx  = 1'b1;
        end
      end
      default: state_nx = TX_IDLE;
    endcase
    if (start && ready) begin
      state_nx = TX_START;
      timer_nx = BIT_LAST;
      shreg_nx = data;
      line_nx  = 1'b0;
    end
  end

endmodule

// File: rtl/uart_loopback_top.sv
// UART loopback top: sequences a 64-bit word out as 8 back-to-back 8N1
// frames (MSB byte first) and deserialises the looped-back line into
// data_out_64. Optional macro TOP_EDGE_START_EN: start a burst only on a
// rising edge of manual_start instead of while it is held high.
//
// state    | meaning
// ---------+----------------------------------------------------
// TX_IDLE  | sequencer waiting for a start request
// TX_LOAD  | byte byte_cnt offered to uart_tx until it is accepted
// TX_NEXT  | advance byte_cnt, or wait for the last frame to end
// RX_IDLE  | waiting for a 1->0 transition on the line
// RX_START | mid start-bit check, false start returns to idle
// RX_DATA  | sampling 8 data bits, LSB first
// RX_STOP  | stop-bit sample: accept byte or drop the partial word
module uart_loopback_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = uart_pkg::CLK_FREQ,
  parameter int BAUD     = uart_pkg::BAUD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        manual_start,
  input  logic [63:0] data_in_64,
  output logic [63:0] data_out_64
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int TW       = $clog2(BAUD_DIV);
  localparam logic [TW-1:0] BIT_LAST = TW'(BAUD_DIV - 1);
  // Sampling one cycle before the half point keeps the sample centred
  // once the line-edge register delay is included.
  localparam logic [TW-1:0] HALF_LD  = TW'(HALF_DIV - 2);

  logic start_req;

`ifdef TOP_EDGE_START_EN
  logic start_q;

  // Previous manual_start, for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b0;
    else        start_q <= manual_start;
  end

  assign start_req = manual_start & ~start_q;
`else
  assign start_req = manual_start;
`endif

  tx_state_t   seq, seq_nx;
  logic [2:0]  byte_cnt, byte_cnt_nx;
  logic [63:0] tx_buf, tx_buf_nx;
  logic        tx_start, tx_busy, tx_ready, tx_done, tx_line;
  logic [7:0]  tx_byte;
  logic        rx_line;

  assign rx_line = tx_line;
  assign tx_byte = byte_sel(tx_buf, byte_cnt);

  uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (tx_start),
    .data  (tx_byte),
    .line  (tx_line),
    .busy  (tx_busy),
    .ready (tx_ready),
    .done  (tx_done)
  );

  // Byte sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq      <= TX_IDLE;
      byte_cnt <= '0;
      tx_buf   <= '0;
    end else begin
      seq      <= seq_nx;
      byte_cnt <= byte_cnt_nx;
      tx_buf   <= tx_buf_nx;
    end
  end

  // Sequencer next-state: the next byte is queued as soon as the current
  // frame starts, so uart_tx can chain it at the end of the stop bit.
  always_comb begin
    seq_nx      = seq;
    byte_cnt_nx = byte_cnt;
    tx_buf_nx   = tx_buf;
    tx_start    = 1'b0;
    case (seq)
      TX_IDLE: begin
        if (start_req && !tx_busy) begin
          tx_buf_nx   = data_in_64;
          byte_cnt_nx = '0;
          seq_nx      = TX_LOAD;
        end
      end
      TX_LOAD: begin
        tx_start = 1'b1;
        if (tx_ready) seq_nx = TX_NEXT;
      end
      TX_NEXT: begin
        if (byte_cnt == 3'(NBYTES - 1)) begin
          if (tx_done) seq_nx = TX_IDLE;
        end else begin
          byte_cnt_nx = byte_cnt + 3'd1;
          seq_nx      = TX_LOAD;
        end
      end
      default: seq_nx = TX_IDLE;
    endcase
  end

  rx_state_t     rx_state, rx_state_nx;
  logic [TW-1:0] rx_timer, rx_timer_nx;
  logic [2:0]    rx_bit, rx_bit_nx;
  logic [7:0]    rx_byte, rx_byte_nx;
  logic [55:0]   rx_acc, rx_acc_nx;
  logic [2:0]    rx_cnt, rx_cnt_nx;
  logic [63:0]   data_out_nx;
  logic          line_q;
  logic          rx_tc;

  assign rx_tc = (rx_timer == '0);

  // Deserialiser registers, line history and the output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state    <= RX_IDLE;
      rx_timer    <= '0;
      rx_bit      <= '0;
      rx_byte     <= '0;
      rx_acc      <= '0;
      rx_cnt      <= '0;
      data_out_64 <= '0;
      line_q      <= 1'b1;
    end else begin
      rx_state    <= rx_state_nx;
      rx_timer    <= rx_timer_nx;
      rx_bit      <= rx_bit_nx;
      rx_byte     <= rx_byte_nx;
      rx_acc      <= rx_acc_nx;
      rx_cnt      <= rx_cnt_nx;
      data_out_64 <= data_out_nx;
      line_q      <= rx_line;
    end
  end

  // Deserialiser next-state; only a complete 8-byte word reaches data_out_64.
  always_comb begin
    rx_state_nx = rx_state;
    rx_timer_nx = rx_tc ? rx_timer : rx_timer - TW'(1);
    rx_bit_nx   = rx_bit;
    rx_byte_nx  = rx_byte;
    rx_acc_nx   = rx_acc;
    rx_cnt_nx   = rx_cnt;
    data_out_nx = data_out_64;
    case (rx_state)
      RX_IDLE: begin
        if (line_q && !rx_line) begin
          rx_state_nx = RX_START;
          rx_timer_nx = HALF_LD;
        end
      end
      RX_START: begin
        if (rx_tc) begin
          if (rx_line) begin
            rx_state_nx = RX_IDLE;
          end else begin
            rx_state_nx = RX_DATA;
            rx_timer_nx = BIT_LAST;
            rx_bit_nx   = '0;
          end
        end
      end
      RX_DATA: begin
        if (rx_tc) begin
          rx_byte_nx  = {rx_line, rx_byte[7:1]};
          rx_timer_nx = BIT_LAST;
          if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
          else                rx_bit_nx   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_tc) begin
          rx_state_nx = RX_IDLE;
          if (!rx_line) begin
            rx_cnt_nx = '0;
            rx_acc_nx = '0;
          end else if (rx_cnt == 3'(NBYTES - 1)) begin
            data_out_nx = {rx_acc, rx_byte};
            rx_acc_nx   = {rx_acc[47:0], rx_byte};
            rx_cnt_nx   = '0;
          end else begin
            rx_acc_nx = {rx_acc[47:0], rx_byte};
            rx_cnt_nx = rx_cnt + 3'd1;
          end
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_loopback_top.sv
// Directed/random bench for uart_loopback_top with a byte-queue reference model.
// Runs the DUT at 16 clocks per bit to keep bursts short.
module tb_uart_loopback_top;

  localparam int CLK_FREQ = 1_843_200;
  localparam int BAUD     = 115_200;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int HALF     = DIV / 2;
  localparam int BURST    = 8 * 10 * DIV;
  localparam int LAT      = BURST - HALF;
  localparam logic [63:0] WORD_A = 64'hA1A3_4D6F_F6B2_C581;
  localparam logic [63:0] WORD_B = 64'h4423_3E79_4794_27F7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        manual_start = 1'b0;
  logic [63:0] data_in_64 = '0;
  logic [63:0] data_out_64;

  int          cyc = 0;
  int          t0 = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [7:0]  rxq[$];
  logic [63:0] exp_out = '0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_loopback_top #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .manual_start(manual_start),
    .data_in_64  (data_in_64),
    .data_out_64 (data_out_64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_burst(input logic [63:0] w, input bit hold);
    @(negedge clk);
    data_in_64   = w;
    manual_start = 1'b1;
    t0           = cyc;
    if (!hold) begin
      @(negedge clk);
      manual_start = 1'b0;
    end
  endtask

  task automatic wait_rel(input int n);
    while (cyc - t0 < n) @(negedge clk);
  endtask

  task automatic wait_out(input logic [63:0] w, input int limit);
    for (int i = 0; i < limit && data_out_64 !== w; i++) @(negedge clk);
  endtask

  // Receiver as described: good bytes queue up, a framing error empties the
  // queue, eight queued bytes form the next output word (first byte on top).
  task automatic model_burst(input logic [63:0] w, input int bad);
    for (int k = 0; k < 8; k++) begin
      if (k == bad) begin
        rxq.delete();
      end else begin
        rxq.push_back(w[63-8*k -: 8]);
        if (rxq.size() == 8) begin
          exp_out = '0;
          foreach (rxq[i]) exp_out = {exp_out[55:0], rxq[i]};
          rxq.delete();
        end
      end
    end
  endtask

  initial begin
    logic [63:0] w, prev;
    logic [7:0]  b;
    logic        exp_bit;
    int          lat, zeros;

    // Reset
    @(negedge clk);
    check("rst_out", data_out_64, 64'h0);
    check("rst_line", 64'(dut.tx_line), 64'h1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_out", data_out_64, 64'h0);
    check("post_rst_line", 64'(dut.tx_line), 64'h1);

    // Single word held high, first frame pattern, latency
    w = WORD_A;
    b = w[63:56];
    start_burst(WORD_A, 1'b1);
    for (int i = 0; i < 10 && dut.tx_line !== 1'b0; i++) @(negedge clk);
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      exp_bit = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      check($sformatf("frame0_bit%0d", i), 64'(dut.tx_line), 64'(exp_bit));
      if (i < 9) repeat (DIV) @(negedge clk);
    end

    // Input change mid-burst must not leak into the running burst
    wait_rel(BURST / 2);
    data_in_64 = WORD_B;
    model_burst(WORD_A, -1);
    wait_out(exp_out, BURST);
    lat = cyc - t0;
    n_assert++;
    assert (lat >= LAT - 2 && lat <= LAT + 2) else begin
      n_fail++;
      $error("FAIL latency: observed %0d cycles expected %0d +/-2", lat, LAT);
    end
    check("word_a", data_out_64, exp_out);

`ifdef TOP_EDGE_START_EN
    repeat (DIV) @(negedge clk);
    manual_start = 1'b0;
    @(negedge clk);
    manual_start = 1'b1;
    @(negedge clk);
    manual_start = 1'b0;
`else
    repeat (2 * DIV) @(negedge clk);
    manual_start = 1'b0;
`endif
    model_burst(WORD_B, -1);
    wait_out(exp_out, BURST + 4 * DIV);
    check("word_b", data_out_64, exp_out);
    repeat (2 * DIV) @(negedge clk);

    // Random words
    for (int n = 0; n < 3; n++) begin
      w = {$urandom, $urandom};
      start_burst(w, 1'b0);
      model_burst(w, -1);
      wait_rel(BURST + DIV);
      check($sformatf("rand%0d", n), data_out_64, exp_out);
    end

    // Reset during byte 4
    w = {$urandom, $urandom};
    start_burst(w, 1'b0);
    wait_rel(45 * DIV);
    rst_n = 1'b0;
    #1;
    rxq.delete();
    exp_out = '0;
    check("midrst_out", data_out_64, exp_out);
    check("midrst_line", 64'(dut.tx_line), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("after_midrst_out", data_out_64, exp_out);
    check("after_midrst_line", 64'(dut.tx_line), 64'h1);
    w = {$urandom, $urandom};
    start_burst(w, 1'b0);
    model_burst(w, -1);
    wait_rel(BURST + DIV);
    check("fresh_after_rst", data_out_64, exp_out);

    // Framing error on byte 3's stop bit
    w = {$urandom, $urandom};
    prev = data_out_64;
    start_burst(w, 1'b0);
    wait_rel(2 + 39 * DIV + 3);
    force dut.rx_line = 1'b0;
    wait_rel(2 + 40 * DIV - 3);
    release dut.rx_line;
    check("frame_err_mid", data_out_64, prev);
    model_burst(w, 3);
    wait_rel(BURST + DIV);
    check("frame_err_hold", data_out_64, exp_out);

    // Leftover good bytes combine with the next burst
    w = {$urandom, $urandom};
    start_burst(w, 1'b0);
    model_burst(w, -1);
    wait_rel(BURST + DIV);
    check("after_frame_err", data_out_64, exp_out);

`ifdef TOP_EDGE_START_EN
    // Held level sends exactly one burst
    w = {$urandom, $urandom};
    start_burst(w, 1'b1);
    model_burst(w, -1);
    wait_rel(BURST + 2 * DIV);
    check("edge_once", data_out_64, exp_out);
    zeros = 0;
    repeat (20 * BURST) begin
      @(negedge clk);
      if (dut.tx_line !== 1'b1) zeros++;
    end
    check("edge_idle_zeros", 64'(zeros), 64'h0);
    manual_start = 1'b0;
`else
    zeros = 0;
    repeat (4 * DIV) begin
      @(negedge clk);
      if (dut.tx_line !== 1'b1) zeros++;
    end
    check("idle_zeros", 64'(zeros), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
